// File: rtl/ps2_key_ctrl.sv
// PS/2 key-event controller: pops the receive FIFO, strips set-2 E0/F0 prefixes,
// tracks the last pressed key and synthesises timed auto-repeat events.
module ps2_key_ctrl #(
  parameter int unsigned REPEAT_DELAY = 6250000,
  parameter int unsigned REPEAT_RATE  = 1250000,
  parameter int unsigned CNT_W        = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  input  logic       rep_en,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_repeat,
  output logic       key_valid,
  output logic       held
);

  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {RD_IDLE, RD_POP, RD_CAPT} rd_state_t;
  typedef enum logic [1:0] {DEC_BASE, DEC_EXT, DEC_BRK, DEC_EXTBRK} dec_state_t;

  rd_state_t     r_rd_st;
  dec_state_t    r_dec;
  logic          r_fifo_rd;
  logic [DW-1:0] r_key_code;
  logic          r_key_ext;
  logic          r_key_break;
  logic          r_key_repeat;
  logic          r_key_valid;
  logic          r_held;
  logic [DW-1:0] r_trk_code;
  logic          r_trk_ext;
  logic [CNT_W-1:0] r_cnt;
  logic          r_rep_en_q;

  dec_state_t    w_dec_nxt;
  logic          w_ev_vld;
  logic          w_ev_ext;
  logic          w_ev_brk;
  logic          w_discard;
  logic          w_same;
  logic          w_typematic;
  logic          w_emit;
  logic          w_expire;
  logic          w_rep_rise;

  assign fifo_rd    = r_fifo_rd;
  assign key_code   = r_key_code;
  assign key_ext    = r_key_ext;
  assign key_break  = r_key_break;
  assign key_repeat = r_key_repeat;
  assign key_valid  = r_key_valid;
  assign held       = r_held;

  assign w_discard = fifo_data inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  // Prefix decoder: one step per byte, only in the capture cycle
  always_comb begin
    w_dec_nxt = r_dec;
    w_ev_vld  = 1'b0;
    w_ev_ext  = 1'b0;
    w_ev_brk  = 1'b0;
    if (r_rd_st == RD_CAPT) begin
      case (r_dec)
        DEC_BASE: begin
          if (fifo_data == 8'hE0)      w_dec_nxt = DEC_EXT;
          else if (fifo_data == 8'hF0) w_dec_nxt = DEC_BRK;
          else if (!w_discard)         w_ev_vld  = 1'b1;
        end
        DEC_EXT: begin
          if (fifo_data == 8'hF0) begin
            w_dec_nxt = DEC_EXTBRK;
          end else if (fifo_data != 8'hE0) begin
            w_ev_vld  = 1'b1;
            w_ev_ext  = 1'b1;
            w_dec_nxt = DEC_BASE;
          end
        end
        DEC_BRK: begin
          w_ev_vld  = 1'b1;
          w_ev_brk  = 1'b1;
          w_dec_nxt = DEC_BASE;
        end
        default: begin
          w_ev_vld  = 1'b1;
          w_ev_brk  = 1'b1;
          w_ev_ext  = 1'b1;
          w_dec_nxt = DEC_BASE;
        end
      endcase
    end
  end

  assign w_same      = ({w_ev_ext, fifo_data} == {r_trk_ext, r_trk_code});
  assign w_typematic = w_ev_vld && !w_ev_brk && w_same && r_held;
  assign w_emit      = w_ev_vld && !w_typematic;
  assign w_expire    = r_held && rep_en && (r_cnt == CNT_W'(1));
  assign w_rep_rise  = rep_en && !r_rep_en_q;

  // Read sequencer: IDLE -> POP -> CAPT, plus decoder state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_st   <= RD_IDLE;
      r_dec     <= DEC_BASE;
      r_fifo_rd <= 1'b0;
    end else begin
      r_fifo_rd <= 1'b0;
      r_dec     <= w_dec_nxt;
      case (r_rd_st)
        RD_IDLE: begin
          if (!fifo_empty) begin
            r_rd_st   <= RD_POP;
            r_fifo_rd <= 1'b1;
          end
        end
        RD_POP:  r_rd_st <= RD_CAPT;
        default: r_rd_st <= RD_IDLE;
      endcase
    end
  end

  // Event output, key tracking and repeat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_code   <= '0;
      r_key_ext    <= 1'b0;
      r_key_break  <= 1'b0;
      r_key_repeat <= 1'b0;
      r_key_valid  <= 1'b0;
      r_held       <= 1'b0;
      r_trk_code   <= '0;
      r_trk_ext    <= 1'b0;
      r_cnt        <= '0;
      r_rep_en_q   <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_rep_en_q  <= rep_en;
      if (w_emit) begin
        r_key_valid  <= 1'b1;
        r_key_code   <= fifo_data;
        r_key_ext    <= w_ev_ext;
        r_key_break  <= w_ev_brk;
        r_key_repeat <= 1'b0;
        if (!w_ev_brk) begin
          r_trk_code <= fifo_data;
          r_trk_ext  <= w_ev_ext;
          r_held     <= 1'b1;
        end else if (w_same) begin
          r_held <= 1'b0;
        end
      end else if (w_expire && !w_rep_rise) begin
        r_key_valid  <= 1'b1;
        r_key_code   <= r_trk_code;
        r_key_ext    <= r_trk_ext;
        r_key_break  <= 1'b0;
        r_key_repeat <= 1'b1;
      end

      // A decoded event on the expiry cycle drops the repeat but keeps the cadence
      if (w_emit && !w_ev_brk)                 r_cnt <= CNT_W'(REPEAT_DELAY);
      else if (w_emit && w_ev_brk && w_same)   r_cnt <= '0;
      else if (w_rep_rise && r_held)           r_cnt <= CNT_W'(REPEAT_DELAY);
      else if (w_expire)                       r_cnt <= CNT_W'(REPEAT_RATE);
      else if (r_held && rep_en && (r_cnt > CNT_W'(1))) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl with short repeat timing (delay 20, rate 5).
module tb_ps2_key_ctrl;

  typedef struct {
    int         cyc;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic       hld;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd;
  logic       rep_en = 1'b0;
  logic [7:0] key_code;
  logic       key_ext, key_break, key_repeat, key_valid, held;

  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;
  ev_t        evq[$];

  ps2_key_ctrl #(.REPEAT_DELAY(20), .REPEAT_RATE(5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .rep_en(rep_en), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .key_repeat(key_repeat), .key_valid(key_valid), .held(held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_empty = (rd_ptr == wr_ptr);

  // FIFO model: data presented the cycle after the pop strobe
  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1)
      evq.push_back('{cyc, key_code, key_ext, key_break, key_repeat, held});
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic chk_ev(input string name, input int idx, input int ecyc, input logic [7:0] ecode,
                        input logic eext, input logic ebrk, input logic erep, input logic ehld);
    n_total++;
    if (idx >= evq.size()) begin
      $display("FAIL %s: event %0d missing (have %0d)", name, idx, evq.size());
    end else if (evq[idx].cyc !== ecyc || evq[idx].code !== ecode || evq[idx].ext !== eext ||
                 evq[idx].brk !== ebrk || evq[idx].rep !== erep || evq[idx].hld !== ehld) begin
      $display("FAIL %s: got cyc=%0d code=%h ext=%b brk=%b rep=%b held=%b, want cyc=%0d code=%h ext=%b brk=%b rep=%b held=%b",
               name, evq[idx].cyc, evq[idx].code, evq[idx].ext, evq[idx].brk, evq[idx].rep, evq[idx].hld,
               ecyc, ecode, eext, ebrk, erep, ehld);
    end else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({fifo_rd, key_code, key_ext, key_break, key_repeat, key_valid, held} !== 13'h0)
      $display("FAIL reset_outputs: got %h want 0",
               {fifo_rd, key_code, key_ext, key_break, key_repeat, key_valid, held});
    else n_pass++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_make();
    int c0;
    evq.delete();
    c0 = cyc;
    push(8'h1D);
    @(negedge clk);
    n_total++;
    if (fifo_rd !== 1'b1) $display("FAIL pop_cycle1: got %b want 1", fifo_rd); else n_pass++;
    @(negedge clk);
    n_total++;
    if (fifo_rd !== 1'b0) $display("FAIL pop_cycle2: got %b want 0", fifo_rd); else n_pass++;
    @(negedge clk);
    n_total++;
    if ({key_valid, key_code, key_ext, key_break, key_repeat, held} !== {1'b1, 8'h1D, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL make_1d: got v=%b code=%h ext=%b brk=%b rep=%b held=%b want v=1 code=1d 0 0 0 held=1",
               key_valid, key_code, key_ext, key_break, key_repeat, held);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (key_valid !== 1'b0 || key_code !== 8'h1D)
      $display("FAIL make_hold: got v=%b code=%h want v=0 code=1d", key_valid, key_code);
    else n_pass++;
    c0 = cyc;
    push(8'hF0);
    push(8'h1D);
    wait_until(c0 + 10);
    n_total++;
    if (evq.size() !== 2) $display("FAIL break_1d_count: got %0d want 2", evq.size()); else n_pass++;
    chk_ev("break_1d", 1, c0 + 6, 8'h1D, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_ext_break();
    int c0;
    c0 = cyc;
    evq.delete();
    push(8'hE0);
    push(8'h75);
    wait_until(c0 + 10);
    chk_ev("make_e075", 0, c0 + 6, 8'h75, 1'b1, 1'b0, 1'b0, 1'b1);
    evq.delete();
    c0 = cyc;
    push(8'hE0);
    push(8'hF0);
    push(8'h75);
    wait_until(c0 + 14);
    n_total++;
    if (evq.size() !== 1) $display("FAIL ext_break_count: got %0d want 1", evq.size()); else n_pass++;
    chk_ev("ext_break_75", 0, c0 + 9, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_repeat();
    int c0;
    rep_en = 1'b1;
    repeat (2) @(negedge clk);
    evq.delete();
    c0 = cyc;
    push(8'h1C);
    wait_until(c0 + 8);
    push(8'h1C);
    wait_until(c0 + 24);
    push(8'h1C);
    wait_until(c0 + 35);
    rep_en = 1'b0;
    n_total++;
    if (evq.size() !== 4) $display("FAIL repeat_count: got %0d want 4", evq.size()); else n_pass++;
    chk_ev("repeat_make", 0, c0 + 3,  8'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_ev("repeat_1",    1, c0 + 23, 8'h1C, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_ev("repeat_2",    2, c0 + 28, 8'h1C, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_ev("repeat_3",    3, c0 + 33, 8'h1C, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_rollover();
    int c0;
    int c1;
    repeat (3) @(negedge clk);
    evq.delete();
    c0 = cyc;
    push(8'h23);
    push(8'hF0);
    push(8'h1C);
    wait_until(c0 + 12);
    n_total++;
    if (evq.size() !== 2) $display("FAIL rollover_count: got %0d want 2", evq.size()); else n_pass++;
    chk_ev("rollover_make_23",  0, c0 + 3, 8'h23, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_ev("rollover_break_1c", 1, c0 + 9, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b1);
    evq.delete();
    c1 = cyc;
    rep_en = 1'b1;
    wait_until(c1 + 28);
    n_total++;
    if (evq.size() !== 2) $display("FAIL rollover_rep_count: got %0d want 2", evq.size()); else n_pass++;
    chk_ev("rollover_rep_1", 0, c1 + 21, 8'h23, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_ev("rollover_rep_2", 1, c1 + 26, 8'h23, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_collision();
    int r;
    int n;
    evq.delete();
    n = 0;
    while (evq.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (evq.size() == 0) begin
      $display("FAIL collision_sync: got no repeat within 20 cycles, want one");
      return;
    end
    n_pass++;
    r = evq[0].cyc;
    wait_until(r + 4);
    push(8'hF0);
    push(8'h1A);
    wait_until(r + 17);
    n_total++;
    if (evq.size() !== 4) $display("FAIL collision_count: got %0d want 4", evq.size()); else n_pass++;
    chk_ev("collision_rep_before", 1, r + 5,  8'h23, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_ev("collision_break_1a",   2, r + 10, 8'h1A, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_ev("collision_rep_after",  3, r + 15, 8'h23, 1'b0, 1'b0, 1'b1, 1'b1);
    rep_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int c0;
    repeat (3) @(negedge clk);
    c0 = cyc;
    push(8'hF0);
    wait_until(c0 + 4);
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({fifo_rd, key_code, key_ext, key_break, key_repeat, key_valid, held} !== 13'h0)
      $display("FAIL reset_mid_outputs: got %h want 0",
               {fifo_rd, key_code, key_ext, key_break, key_repeat, key_valid, held});
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    evq.delete();
    c0 = cyc;
    push(8'h1D);
    wait_until(c0 + 8);
    n_total++;
    if (evq.size() !== 1) $display("FAIL reset_mid_count: got %0d want 1", evq.size()); else n_pass++;
    chk_ev("reset_mid_make_1d", 0, c0 + 3, 8'h1D, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic_make();
    test_ext_break();
    test_repeat();
    test_rollover();
    test_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
